run_sequencer: RTL



---
 rtl/run_seq_pkg.sv | 8 +
 rtl/run_sequencer_result_streamer.sv | 64 ++++++
 rtl/run_sequencer.sv | 94 +++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared state encoding and default parameters for run_sequencer
package run_seq_pkg;
  typedef enum logic [2:0] {IDLE, RST, REQ, RUN, DRAIN, FIN} run_state_t;
  localparam int RST_CYC_DEF  = 2;
  localparam int MAX_CYC_DEF  = 16'hFFFF;
  localparam int RES_BASE_DEF = 64;
  localparam int RES_LEN_DEF  = 32;
endpackage

// File: rtl/run_sequencer_result_streamer.sv
// result_streamer: reads RES_LEN bytes from RES_BASE and streams them over valid/ready
//   in : clk, reset, go (drain enabled), clear (new run), mem_rd_data, out_ready
//   out: mem_addr, out_valid, out_data, last_done (final byte accepted), checksum (RUN_SEQ_CHECKSUM_EN)
module result_streamer
  import run_seq_pkg::*;
#(
  parameter int D        = 8,
  parameter int RES_BASE = RES_BASE_DEF,
  parameter int RES_LEN  = RES_LEN_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic         clear,
  input  logic [7:0]   mem_rd_data,
  input  logic         out_ready,
  output logic [D-1:0] mem_addr,
  output logic         out_valid,
  output logic [7:0]   out_data,
`ifdef RUN_SEQ_CHECKSUM_EN
  output logic [7:0]   checksum,
`endif
  output logic         last_done
);
  logic [D:0]   idx_q;
  logic [D-1:0] addr_q;
  logic         valid_q;
  logic [7:0]   data_q;
  logic         more, hs, load;
  assign more      = idx_q < (D+1)'(RES_LEN);
  assign hs        = go && valid_q && out_ready;
  assign load      = go && (!valid_q || out_ready) && more;
  assign last_done = hs && !more;
  assign mem_addr  = addr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  // addr_q always tracks RES_BASE+idx so the combinational read is ready at load time
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      addr_q  <= D'(RES_BASE);
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      addr_q <= D'(RES_BASE);
    end else begin
      if (load) begin
        idx_q  <= idx_q + 1'b1;
        addr_q <= addr_q + 1'b1;
        data_q <= mem_rd_data;
      end
      valid_q <= load || (valid_q && !hs);
    end
  end
`ifdef RUN_SEQ_CHECKSUM_EN
  logic [7:0] sum_q;
  assign checksum = sum_q;
  always_ff @(posedge clk) begin
    if (reset || clear) sum_q <= '0;
    else if (hs) sum_q <= sum_q + data_q;
  end
`endif
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: resets and starts the core, times its run, then streams the result window
//   in : clk, reset, start, core_done, mem_rd_data, out_ready
//   out: core_reset, core_req, mem_addr, out_valid, out_data, busy, timeout, cycle_count
//   RUN_SEQ_CHECKSUM_EN adds checksum (mod-256 sum of bytes streamed this run)
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int D        = 8,
  parameter int W        = 16,
  parameter int RST_CYC  = RST_CYC_DEF,
  parameter int MAX_CYC  = MAX_CYC_DEF,
  parameter int RES_BASE = RES_BASE_DEF,
  parameter int RES_LEN  = RES_LEN_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         core_reset,
  output logic         core_req,
  input  logic         core_done,
  output logic [D-1:0] mem_addr,
  input  logic [7:0]   mem_rd_data,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
`ifdef RUN_SEQ_CHECKSUM_EN
  output logic [7:0]   checksum,
`endif
  output logic         busy,
  output logic         timeout,
  output logic [W-1:0] cycle_count
);
  run_state_t   state_q;
  logic [W-1:0] cnt_q, rst_cnt_q;
  logic         core_reset_q, core_req_q, timeout_q, last_done;
  assign busy        = state_q != IDLE;
  assign core_reset  = core_reset_q;
  assign core_req    = core_req_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      core_reset_q <= 1'b1;
      core_req_q   <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
      rst_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q      <= RST;
          core_reset_q <= 1'b1;
          timeout_q    <= 1'b0;
          cnt_q        <= '0;
          rst_cnt_q    <= '0;
        end else core_reset_q <= 1'b0;
        RST: if (rst_cnt_q == W'(RST_CYC - 1)) begin
          state_q      <= REQ;
          core_reset_q <= 1'b0;
          core_req_q   <= 1'b1;
        end else rst_cnt_q <= rst_cnt_q + 1'b1;
        REQ: begin
          state_q    <= RUN;
          core_req_q <= 1'b0;
        end
        // done is checked first so it wins a tie with the cycle limit
        RUN: if (core_done) state_q <= DRAIN;
        else if (cnt_q == W'(MAX_CYC)) begin
          timeout_q <= 1'b1;
          state_q   <= FIN;
        end else cnt_q <= cnt_q + 1'b1;
        DRAIN: if (last_done) state_q <= FIN;
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  result_streamer #(.D(D), .RES_BASE(RES_BASE), .RES_LEN(RES_LEN)) u_streamer (
    .clk         (clk),
    .reset       (reset),
    .go          (state_q == DRAIN),
    .clear       (state_q == IDLE && start),
    .mem_rd_data (mem_rd_data),
    .out_ready   (out_ready),
    .mem_addr    (mem_addr),
    .out_valid   (out_valid),
    .out_data    (out_data),
`ifdef RUN_SEQ_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .last_done   (last_done)
  );
endmodule
